// File: rtl/if_stage_pipelined.sv
// ---------------------------------------------------------------------------
// if_stage_pipelined
//   Instruction-fetch stage with a registered IF/ID output register.
//   A program counter walks word-aligned addresses through a local
//   instruction memory. Each fetched word is captured into the IF/ID
//   register together with its byte address and that address + 4.
//   Decode consumes the register through a valid/ready handshake.
//   A branch redirect from EX/MEM reloads the PC and flushes the one
//   wrong-path instruction. A write port loads the instruction memory.
//
// Ports
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   in_PCSrc           in   redirect request, takes in_branch_address
//   in_branch_address  in   redirect target byte address
//   id_ready           in   decode accepts the IF/ID register this cycle
//   imem_we            in   instruction memory write enable
//   imem_waddr         in   word index to write
//   imem_wdata         in   word to write
//   instruction_out    out  registered fetched instruction
//   pc_out             out  registered byte address of instruction_out
//   pc_plus_four_out   out  registered pc_out + 4
//   out_valid          out  IF/ID register holds a live instruction
//   fetch_fault        out  sticky out-of-range / misaligned-redirect flag
//
// Handshake: the IF/ID register transfers to decode on a cycle where
// out_valid=1 and id_ready=1. While out_valid=1 and id_ready=0, every
// output holds, unless a redirect (in_PCSrc=1) arrives. A redirect
// drops out_valid and leaves the other output registers untouched.
// ---------------------------------------------------------------------------
module if_stage_pipelined #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned IMEM_DEPTH = 4000,
   parameter int unsigned RESET_PC   = 0,
   localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_PCSrc,
   input  logic [DATA_W-1:0] in_branch_address,
   input  logic              id_ready,
   input  logic              imem_we,
   input  logic [AW-1:0]     imem_waddr,
   input  logic [DATA_W-1:0] imem_wdata,
   output logic [DATA_W-1:0] instruction_out,
   output logic [DATA_W-1:0] pc_out,
   output logic [DATA_W-1:0] pc_plus_four_out,
   output logic              out_valid,
   output logic              fetch_fault
);

   // Instruction memory. This array is not reset.
   logic [DATA_W-1:0] imem_q [IMEM_DEPTH];

   logic [DATA_W-1:0] pc_q,    pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] pco_q,   pco_d;
   logic [DATA_W-1:0] pc4o_q,  pc4o_d;
   logic              valid_q, valid_d;
   logic              fault_q, fault_d;

   logic              redirect;
   logic              advance;
   logic [DATA_W-1:0] pc_plus_four;
   logic [DATA_W-1:0] word_idx;
   logic              in_range;
   logic [DATA_W-1:0] rd_word;

   // A case-equality compare makes an X or Z on the request read as
   // "no redirect" in simulation. Synthesis sees a plain compare.
   assign redirect     = (in_PCSrc === 1'b1);
   assign advance      = !valid_q || id_ready;
   assign pc_plus_four = pc_q + DATA_W'(4);
   assign word_idx     = pc_q >> 2;
   assign in_range     = word_idx < DATA_W'(IMEM_DEPTH);

   // The read is combinational from the pre-edge array contents. A write
   // to the same word on the same edge is therefore not seen until the
   // next fetch of that word.
   always_comb begin
      rd_word = '0;
      if (in_range) rd_word = imem_q[word_idx[AW-1:0]];
   end

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pco_d   = pco_q;
      pc4o_d  = pc4o_q;
      valid_d = valid_q;
      fault_d = fault_q;
      if (redirect) begin
         // A redirect takes priority over a stall. The target is aligned
         // down, and a misaligned target is flagged.
         pc_d    = {in_branch_address[DATA_W-1:2], 2'b00};
         valid_d = 1'b0;
         if (in_branch_address[1:0] != 2'b00) fault_d = 1'b1;
      end else if (advance) begin
         // Out-of-range fetches still deliver a valid NOP (all zero), so
         // the pipeline keeps moving. They also raise the sticky fault.
         instr_d = in_range ? rd_word : '0;
         pco_d   = pc_q;
         pc4o_d  = pc_plus_four;
         valid_d = 1'b1;
         pc_d    = pc_plus_four;
         if (!in_range) fault_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= DATA_W'(RESET_PC);
         instr_q <= '0;
         pco_q   <= '0;
         pc4o_q  <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pco_q   <= pco_d;
         pc4o_q  <= pc4o_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   // Memory write port. It is independent of reset. Indices past the end
   // of the array are dropped.
   always_ff @(posedge clk) begin
      if (imem_we && (32'(imem_waddr) < 32'(IMEM_DEPTH))) begin
         imem_q[imem_waddr] <= imem_wdata;
      end
   end

   assign instruction_out  = instr_q;
   assign pc_out           = pco_q;
   assign pc_plus_four_out = pc4o_q;
   assign out_valid        = valid_q;
   assign fetch_fault      = fault_q;

endmodule

// File: tb/tb_if_stage_pipelined.sv
module tb_if_stage_pipelined;

  localparam int DEPTH = 4000;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_PCSrc;
  logic [31:0]   in_branch_address;
  logic          id_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   instruction_out;
  logic [31:0]   pc_out;
  logic [31:0]   pc_plus_four_out;
  logic          out_valid;
  logic          fetch_fault;

  int vectors = 0;
  int errors  = 0;

  if_stage_pipelined #(.DATA_W(32), .IMEM_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_PCSrc          (in_PCSrc),
    .in_branch_address (in_branch_address),
    .id_ready          (id_ready),
    .imem_we           (imem_we),
    .imem_waddr        (imem_waddr),
    .imem_wdata        (imem_wdata),
    .instruction_out   (instruction_out),
    .pc_out            (pc_out),
    .pc_plus_four_out  (pc_plus_four_out),
    .out_valid         (out_valid),
    .fetch_fault       (fetch_fault)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic vld);
    chk({tag, ".instr"}, instruction_out, ins);
    chk({tag, ".pc"},    pc_out,          pc);
    chk({tag, ".pc4"},   pc_plus_four_out, pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  initial begin
    rst_n = 1'b1; in_PCSrc = 1'b0; in_branch_address = '0; id_ready = 1'b1;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.instr", instruction_out, 32'd0);
    chk("rst.pc",    pc_out, 32'd0);
    chk("rst.pc4",   pc_plus_four_out, 32'd0);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.fault", {31'd0, fetch_fault}, 32'd0);

    // Load imem[0..15] while held in reset.
    for (int i = 0; i < 16; i++) begin
      imem_we = 1'b1; imem_waddr = AW'(i); imem_wdata = word(i);
      step();
    end
    imem_we = 1'b0;
    rst_n = 1'b1;

    // Straight-line fetch A, B.
    step(); chk_out("fetchA", word(0), 32'd0, 1'b1);
    step(); chk_out("fetchB", word(1), 32'd4, 1'b1);

    // Stall three cycles holding B, then C.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("stallB", word(1), 32'd4, 1'b1);
    end
    id_ready = 1'b1;
    step(); chk_out("fetchC", word(2), 32'd8, 1'b1);

    // Redirect to 0x20 while stalled on C: one bubble, other regs hold.
    id_ready = 1'b0; in_PCSrc = 1'b1; in_branch_address = 32'h20;
    step(); chk_out("redir20.bubble", word(2), 32'd8, 1'b0);
    in_PCSrc = 1'b0; id_ready = 1'b1;
    step(); chk_out("redir20.tgt", word(8), 32'h20, 1'b1);
    chk("redir20.fault", {31'd0, fetch_fault}, 32'd0);
    step(); chk_out("redir20.next", word(9), 32'h24, 1'b1);

    // Misaligned redirect to 0x22: fault set, fetch from 0x20.
    in_PCSrc = 1'b1; in_branch_address = 32'h22;
    step();
    chk("mis.bubble.valid", {31'd0, out_valid}, 32'd0);
    chk("mis.fault", {31'd0, fetch_fault}, 32'd1);
    in_PCSrc = 1'b0;
    step(); chk_out("mis.tgt", word(8), 32'h20, 1'b1);
    step(); step();
    chk("mis.sticky", {31'd0, fetch_fault}, 32'd1);

    // Reset pulse clears fault but not memory.
    rst_n = 1'b0; #1;
    chk("rst2.fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst2.valid", {31'd0, out_valid}, 32'd0);
    chk("rst2.pc",    pc_out, 32'd0);
    step(); rst_n = 1'b1;
    step(); chk_out("rst2.fetchA", word(0), 32'd0, 1'b1);

    // Redirect past the end of memory: NOP, valid, fault.
    in_PCSrc = 1'b1; in_branch_address = 32'(4 * DEPTH);
    step();
    chk("oor.bubble.valid", {31'd0, out_valid}, 32'd0);
    chk("oor.bubble.fault", {31'd0, fetch_fault}, 32'd0);
    in_PCSrc = 1'b0;
    step(); chk_out("oor.nop", 32'd0, 32'(4 * DEPTH), 1'b1);
    chk("oor.fault", {31'd0, fetch_fault}, 32'd1);

    // Write imem[5] while fetching PC=20: old data, then new on refetch.
    in_PCSrc = 1'b1; in_branch_address = 32'd20;
    step();
    in_PCSrc = 1'b0;
    imem_we = 1'b1; imem_waddr = AW'(5); imem_wdata = 32'hDEAD_BEEF;
    step(); chk_out("wr.old", word(5), 32'd20, 1'b1);
    imem_we = 1'b0;
    in_PCSrc = 1'b1; in_branch_address = 32'd20;
    step();
    in_PCSrc = 1'b0;
    step(); chk_out("wr.new", 32'hDEAD_BEEF, 32'd20, 1'b1);

    // PC wrap: 0xFFFFFFFC is out of range, pc+4 wraps to 0.
    in_PCSrc = 1'b1; in_branch_address = 32'hFFFF_FFFC;
    step();
    in_PCSrc = 1'b0;
    step(); chk_out("wrap.top", 32'd0, 32'hFFFF_FFFC, 1'b1);
    step(); chk_out("wrap.zero", word(0), 32'd0, 1'b1);

    // Reset while a redirect is requested: redirect does not survive.
    in_PCSrc = 1'b1; in_branch_address = 32'h40;
    #2 rst_n = 1'b0;
    #1;
    chk("rstredir.valid", {31'd0, out_valid}, 32'd0);
    chk("rstredir.pc", pc_out, 32'd0);
    step();
    rst_n = 1'b1; in_PCSrc = 1'b0;
    step(); chk_out("rstredir.A", word(0), 32'd0, 1'b1);
    step(); chk_out("rstredir.B", word(1), 32'd4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Backstop: the directed sequence is short, so this never fires normally.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
